// File: rtl/i2c_slave_byte_ctl.sv
// I2C target byte engine: filtered SCL/SDA, START/STOP detection, 7-bit address match,
// byte receive/transmit with ACK handling and clock stretching toward the host interface.
module i2c_slave_byte_ctl #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic        sysclk_i,
    input  logic        reset_n_i,
    input  logic        enable_i,
    input  logic [6:0]  slave_addr_i,
    input  logic [15:0] dfsr_i,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        scl_oen,
    output logic        sda_oen,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    input  logic        rx_rd_i,
    output logic        tx_req_o,
    input  logic [7:0]  tx_data_i,
    input  logic        tx_valid_i,
    output logic        busy_o,
    output logic        addressed_o,
    output logic        rw_o,
    output logic        nack_o,
    output logic        stop_det_o
);

    localparam logic [3:0] FILT_MAX = 4'(FILT_LEN - 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_TX_LOAD,
        ST_TX_BYTE,
        ST_TX_ACK,
        ST_RX_BYTE,
        ST_RX_ACK,
        ST_IGNORE
    } state_t;

    // Input conditioning: index 0 = SCL, index 1 = SDA
    logic [1:0]             pad_in;
    logic [SYNC_STAGES-1:0] sync_q [2];
    logic [3:0]             fcnt_q [2];
    logic [1:0]             filt_q;
    logic [1:0]             filt_d1_q;
    logic [15:0]            tick_cnt_q;
    logic                   tick;

    assign pad_in = {sda_i, scl_i};
    assign tick   = (tick_cnt_q >= dfsr_i);

    always_ff @(posedge sysclk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            tick_cnt_q <= '0;
            filt_q     <= 2'b11;
            filt_d1_q  <= 2'b11;
            for (int i = 0; i < 2; i++) begin
                sync_q[i] <= '1;
                fcnt_q[i] <= '0;
            end
        end else begin
            tick_cnt_q <= tick ? 16'd0 : tick_cnt_q + 16'd1;
            filt_d1_q  <= filt_q;
            for (int i = 0; i < 2; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], pad_in[i]};
                if (tick) begin
                    if (sync_q[i][SYNC_STAGES-1] != filt_q[i]) begin
                        if (fcnt_q[i] == FILT_MAX) begin
                            filt_q[i] <= sync_q[i][SYNC_STAGES-1];
                            fcnt_q[i] <= '0;
                        end else begin
                            fcnt_q[i] <= fcnt_q[i] + 4'd1;
                        end
                    end else begin
                        fcnt_q[i] <= '0;
                    end
                end
            end
        end
    end

    logic scl_f, sda_f;
    logic scl_rise, scl_fall, sda_rise, sda_fall;
    logic start_det, stop_det;

    assign scl_f     = filt_q[0];
    assign sda_f     = filt_q[1];
    assign scl_rise  = filt_q[0] & ~filt_d1_q[0];
    assign scl_fall  = ~filt_q[0] & filt_d1_q[0];
    assign sda_rise  = filt_q[1] & ~filt_d1_q[1];
    assign sda_fall  = ~filt_q[1] & filt_d1_q[1];
    assign start_det = sda_fall & scl_f;
    assign stop_det  = sda_rise & scl_f;

    // Protocol engine state
    state_t     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic       rw_q, rw_d;
    logic       addressed_q, addressed_d;
    logic       busy_q, busy_d;
    logic       sda_oen_q, sda_oen_d;
    logic       scl_hold_q, scl_hold_d;
    logic       tx_req_q, tx_req_d;
    logic       tx_have_q, tx_have_d;
    logic       fall_seen_q, fall_seen_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       nack_q, nack_d;
    logic       stop_q, stop_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] tx_buf_q, tx_buf_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] addr_byte;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rw_d        = rw_q;
        addressed_d = addressed_q;
        busy_d      = busy_q;
        sda_oen_d   = sda_oen_q;
        scl_hold_d  = scl_hold_q;
        tx_req_d    = tx_req_q;
        tx_have_d   = tx_have_q;
        fall_seen_d = fall_seen_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q & ~rx_rd_i;
        nack_d      = 1'b0;
        stop_d      = 1'b0;
        shift_d     = shift_q;
        tx_buf_d    = tx_buf_q;
        tx_shift_d  = tx_shift_q;
        addr_byte   = {shift_q[6:0], sda_f};

        // The host may hand over the next byte any time it is requested
        if (tx_req_q && tx_valid_i) begin
            tx_buf_d  = tx_data_i;
            tx_have_d = 1'b1;
            tx_req_d  = 1'b0;
        end

        if (!enable_i) begin
            state_d     = ST_IDLE;
            sda_oen_d   = 1'b1;
            scl_hold_d  = 1'b0;
            rx_valid_d  = 1'b0;
            tx_req_d    = 1'b0;
            tx_have_d   = 1'b0;
            busy_d      = 1'b0;
            addressed_d = 1'b0;
        end else if (start_det) begin
            state_d     = ST_ADDR;
            bit_cnt_d   = '0;
            busy_d      = 1'b1;
            addressed_d = 1'b0;
            sda_oen_d   = 1'b1;
            scl_hold_d  = 1'b0;
            tx_req_d    = 1'b0;
            tx_have_d   = 1'b0;
        end else if (stop_det) begin
            state_d     = ST_IDLE;
            busy_d      = 1'b0;
            addressed_d = 1'b0;
            stop_d      = 1'b1;
            sda_oen_d   = 1'b1;
            scl_hold_d  = 1'b0;
            tx_req_d    = 1'b0;
            tx_have_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = addr_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            if (addr_byte[7:1] == slave_addr_i && slave_addr_i != 7'd0) begin
                                rw_d        = addr_byte[0];
                                addressed_d = 1'b1;
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        sda_oen_d = 1'b0;
                        tx_req_d  = rw_q;
                        state_d   = ST_ADDR_ACK;
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        sda_oen_d = 1'b1;
                        bit_cnt_d = '0;
                        if (rw_q) begin
                            fall_seen_d = 1'b1;
                            state_d     = ST_TX_LOAD;
                        end else begin
                            state_d = ST_RX_BYTE;
                        end
                    end
                end
                ST_TX_LOAD: begin
                    // SDA may only move once SCL is low after the ACK clock
                    if (!fall_seen_q) begin
                        if (scl_fall) fall_seen_d = 1'b1;
                    end else if (tx_have_q) begin
                        tx_shift_d = tx_buf_q;
                        sda_oen_d  = tx_buf_q[7];
                        tx_have_d  = 1'b0;
                        bit_cnt_d  = '0;
                        state_d    = ST_TX_BYTE;
                    end else begin
                        scl_hold_d = 1'b1;
                    end
                end
                ST_TX_BYTE: begin
                    // SCL is released one cycle after the MSB is already on SDA
                    scl_hold_d = 1'b0;
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd7) begin
                            sda_oen_d = 1'b1;
                            state_d   = ST_TX_ACK;
                        end else begin
                            sda_oen_d  = tx_shift_q[6];
                            tx_shift_d = {tx_shift_q[6:0], 1'b0};
                            bit_cnt_d  = bit_cnt_q + 4'd1;
                        end
                    end
                end
                ST_TX_ACK: begin
                    if (scl_rise) begin
                        if (!sda_f) begin
                            tx_req_d    = 1'b1;
                            fall_seen_d = 1'b0;
                            state_d     = ST_TX_LOAD;
                        end else begin
                            nack_d  = 1'b1;
                            state_d = ST_IGNORE;
                        end
                    end
                end
                ST_RX_BYTE: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = {shift_q[6:0], sda_f};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (bit_cnt_q == 4'd8 && (scl_fall || scl_hold_q)) begin
                        if (rx_valid_q) begin
                            scl_hold_d = 1'b1;
                        end else begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                            sda_oen_d  = 1'b0;
                            state_d    = ST_RX_ACK;
                        end
                    end
                end
                ST_RX_ACK: begin
                    scl_hold_d = 1'b0;
                    if (scl_fall) begin
                        sda_oen_d = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = ST_RX_BYTE;
                    end
                end
                ST_IDLE, ST_IGNORE: begin
                    sda_oen_d  = 1'b1;
                    scl_hold_d = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sysclk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            rw_q        <= 1'b0;
            addressed_q <= 1'b0;
            busy_q      <= 1'b0;
            sda_oen_q   <= 1'b1;
            scl_hold_q  <= 1'b0;
            tx_req_q    <= 1'b0;
            tx_have_q   <= 1'b0;
            fall_seen_q <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            nack_q      <= 1'b0;
            stop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rw_q        <= rw_d;
            addressed_q <= addressed_d;
            busy_q      <= busy_d;
            sda_oen_q   <= sda_oen_d;
            scl_hold_q  <= scl_hold_d;
            tx_req_q    <= tx_req_d;
            tx_have_q   <= tx_have_d;
            fall_seen_q <= fall_seen_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            nack_q      <= nack_d;
            stop_q      <= stop_d;
        end
    end

    // Shift and buffer registers carry data only; their contents are qualified by state
    always_ff @(posedge sysclk_i) begin
        shift_q    <= shift_d;
        tx_buf_q   <= tx_buf_d;
        tx_shift_q <= tx_shift_d;
    end

    assign scl_oen     = ~scl_hold_q;
    assign sda_oen     = sda_oen_q;
    assign rx_data_o   = rx_data_q;
    assign rx_valid_o  = rx_valid_q;
    assign tx_req_o    = tx_req_q;
    assign busy_o      = busy_q;
    assign addressed_o = addressed_q;
    assign rw_o        = rw_q;
    assign nack_o      = nack_q;
    assign stop_det_o  = stop_q;

endmodule

// File: tb/tb_i2c_slave_byte_ctl.sv
// Directed bench for i2c_slave_byte_ctl: a behavioural I2C master on wired-AND lines
// plus a host side driving the byte handshakes.
module tb_i2c_slave_byte_ctl;

    localparam int T = 20;

    logic        sysclk_i = 1'b0;
    logic        reset_n_i;
    logic        enable_i;
    logic [6:0]  slave_addr_i;
    logic [15:0] dfsr_i;
    logic        scl_oen, sda_oen;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o, rx_rd_i, tx_req_o, tx_valid_i;
    logic [7:0]  tx_data_i;
    logic        busy_o, addressed_o, rw_o, nack_o, stop_det_o;
    logic        scl_m, sda_m, scl_line, sda_line;

    int n_chk = 0;
    int n_bad = 0;
    int stop_cnt = 0, nack_cnt = 0, sda_drv_cnt = 0, addr_hi_cnt = 0;

    always #5 sysclk_i = ~sysclk_i;

    assign scl_line = scl_m & scl_oen;
    assign sda_line = sda_m & sda_oen;

    i2c_slave_byte_ctl dut (
        .sysclk_i    (sysclk_i),
        .reset_n_i   (reset_n_i),
        .enable_i    (enable_i),
        .slave_addr_i(slave_addr_i),
        .dfsr_i      (dfsr_i),
        .scl_i       (scl_line),
        .sda_i       (sda_line),
        .scl_oen     (scl_oen),
        .sda_oen     (sda_oen),
        .rx_data_o   (rx_data_o),
        .rx_valid_o  (rx_valid_o),
        .rx_rd_i     (rx_rd_i),
        .tx_req_o    (tx_req_o),
        .tx_data_i   (tx_data_i),
        .tx_valid_i  (tx_valid_i),
        .busy_o      (busy_o),
        .addressed_o (addressed_o),
        .rw_o        (rw_o),
        .nack_o      (nack_o),
        .stop_det_o  (stop_det_o)
    );

    always @(posedge sysclk_i) begin
        if (stop_det_o)  stop_cnt++;
        if (nack_o)      nack_cnt++;
        if (!sda_oen)    sda_drv_cnt++;
        if (addressed_o) addr_hi_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge sysclk_i);
    endtask

    task automatic scl_release();
        int k;
        k = 0;
        scl_m = 1'b1;
        while (scl_line !== 1'b1 && k < 4000) begin
            cyc(1);
            k++;
        end
        if (k >= 4000) check_val("scl_stuck_low", 32'(scl_line), 32'd1);
    endtask

    task automatic clk_bit(input logic b, output logic s);
        sda_m = b;
        cyc(T);
        scl_release();
        cyc(T);
        s = sda_line;
        scl_m = 1'b0;
        cyc(T);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1;
        cyc(T);
        scl_release();
        cyc(T);
        sda_m = 1'b0;
        cyc(T);
        scl_m = 1'b0;
        cyc(T);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        cyc(T);
        scl_release();
        cyc(T);
        sda_m = 1'b1;
        cyc(T);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
        clk_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            d[i] = s;
        end
        clk_bit(nack, s);
    endtask

    task automatic wait_tx_req();
        int k;
        k = 0;
        while (!tx_req_o && k < 4000) begin
            cyc(1);
            k++;
        end
        if (k >= 4000) check_val("tx_req_timeout", 32'(tx_req_o), 32'd1);
    endtask

    task automatic give_tx(input logic [7:0] d);
        tx_data_i  = d;
        tx_valid_i = 1'b1;
        cyc(1);
        tx_valid_i = 1'b0;
    endtask

    task automatic pulse_rd();
        rx_rd_i = 1'b1;
        cyc(1);
        rx_rd_i = 1'b0;
        cyc(1);
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd0, rd1;
        int         s0, s1, s2, s3;

        reset_n_i = 1'b0; enable_i = 1'b1; slave_addr_i = 7'h50; dfsr_i = 16'd0;
        scl_m = 1'b1; sda_m = 1'b1; rx_rd_i = 1'b0; tx_valid_i = 1'b0; tx_data_i = 8'h00;
        cyc(5);
        check_val("rst_scl_oen", 32'(scl_oen), 32'd1);
        check_val("rst_sda_oen", 32'(sda_oen), 32'd1);
        check_val("rst_outs", 32'({rx_data_o, rx_valid_o, tx_req_o, busy_o, addressed_o, rw_o, nack_o, stop_det_o}), 32'd0);
        reset_n_i = 1'b1;
        cyc(10);

        // Master write of two bytes, host reads each one
        s0 = stop_cnt;
        i2c_start();
        check_val("w_busy", 32'(busy_o), 32'd1);
        write_byte(8'hA0, ack);
        check_val("w_addr_ack", 32'(ack), 32'd0);
        check_val("w_rw", 32'(rw_o), 32'd0);
        check_val("w_addressed", 32'(addressed_o), 32'd1);
        write_byte(8'h3C, ack);
        check_val("w_b1_ack", 32'(ack), 32'd0);
        check_val("w_b1_data", 32'({rx_valid_o, rx_data_o}), 32'h13C);
        pulse_rd();
        check_val("w_rd_clear", 32'(rx_valid_o), 32'd0);
        write_byte(8'hC3, ack);
        check_val("w_b2_ack", 32'(ack), 32'd0);
        check_val("w_b2_data", 32'(rx_data_o), 32'hC3);
        pulse_rd();
        i2c_stop();
        check_val("w_stop_cnt", 32'(stop_cnt - s0), 32'd1);
        check_val("w_busy_end", 32'({busy_o, addressed_o}), 32'd0);

        // Wrong address: never driven, never addressed
        s0 = sda_drv_cnt; s1 = addr_hi_cnt;
        i2c_start();
        write_byte(8'hA2, ack);
        check_val("na_addr_nack", 32'(ack), 32'd1);
        write_byte(8'h55, ack);
        check_val("na_data_nack", 32'(ack), 32'd1);
        check_val("na_busy", 32'(busy_o), 32'd1);
        i2c_stop();
        check_val("na_sda_drv", 32'(sda_drv_cnt - s0), 32'd0);
        check_val("na_addressed", 32'(addr_hi_cnt - s1), 32'd0);

        // Master read: ACK first byte, NACK second
        s2 = nack_cnt;
        i2c_start();
        write_byte(8'hA1, ack);
        check_val("r_addr_ack", 32'(ack), 32'd0);
        check_val("r_rw", 32'(rw_o), 32'd1);
        fork
            begin
                read_byte(1'b0, rd0);
                read_byte(1'b1, rd1);
            end
            begin
                wait_tx_req();
                give_tx(8'h96);
                wait_tx_req();
                give_tx(8'h5A);
            end
        join
        check_val("r_byte0", 32'(rd0), 32'h96);
        check_val("r_byte1", 32'(rd1), 32'h5A);
        check_val("r_nack_cnt", 32'(nack_cnt - s2), 32'd1);
        i2c_stop();

        // Host withholds rx_rd_i: SCL stretched after 8th bit of the 2nd byte
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h11, ack);
        check_val("st_b1_data", 32'({rx_valid_o, rx_data_o}), 32'h111);
        fork
            write_byte(8'h22, ack);
            begin
                cyc(600);
                check_val("st_scl_held", 32'(scl_oen), 32'd0);
                check_val("st_old_data", 32'(rx_data_o), 32'h11);
                pulse_rd();
            end
        join
        check_val("st_b2_ack", 32'(ack), 32'd0);
        check_val("st_b2_data", 32'({rx_valid_o, rx_data_o}), 32'h122);
        pulse_rd();
        i2c_stop();

        // Read with late transmit data: SCL held, MSB out before release
        i2c_start();
        write_byte(8'hA1, ack);
        fork
            read_byte(1'b1, rd0);
            begin
                wait_tx_req();
                cyc(300);
                check_val("tx_scl_held", 32'(scl_oen), 32'd0);
                check_val("tx_req_held", 32'(tx_req_o), 32'd1);
                give_tx(8'h3C);
                s3 = 0;
                while (!scl_oen && s3 < 100) begin
                    cyc(1);
                    s3++;
                end
                check_val("tx_msb_first", 32'({scl_oen, sda_oen}), 32'b10);
            end
        join
        check_val("tx_byte", 32'(rd0), 32'h3C);
        i2c_stop();

        // Repeated START mid-write, then read
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h44, ack);
        pulse_rd();
        i2c_start();
        check_val("rs_restart", 32'({busy_o, addressed_o}), 32'b10);
        write_byte(8'hA1, ack);
        check_val("rs_ack", 32'(ack), 32'd0);
        check_val("rs_rw", 32'({addressed_o, rw_o}), 32'b11);
        fork
            read_byte(1'b1, rd0);
            begin
                wait_tx_req();
                give_tx(8'h77);
            end
        join
        check_val("rs_byte", 32'(rd0), 32'h77);
        i2c_stop();

        // Disable mid-transfer forces idle
        i2c_start();
        write_byte(8'hA0, ack);
        enable_i = 1'b0;
        cyc(2);
        check_val("en_off", 32'({busy_o, addressed_o, scl_oen, sda_oen}), 32'b0011);
        enable_i = 1'b1;
        i2c_stop();

        // SDA glitches: 2 samples filtered out, 3 samples seen as START then STOP
        s0 = stop_cnt;
        cyc(20);
        sda_m = 1'b0; cyc(2); sda_m = 1'b1; cyc(30);
        check_val("glitch2_busy", 32'(busy_o), 32'd0);
        check_val("glitch2_stop", 32'(stop_cnt - s0), 32'd0);
        sda_m = 1'b0; cyc(3); sda_m = 1'b1; cyc(30);
        check_val("glitch3_stop", 32'(stop_cnt - s0), 32'd1);

        // Asynchronous reset while stretching in RX_BYTE
        i2c_start();
        write_byte(8'hA0, ack);
        write_byte(8'h01, ack);
        fork
            write_byte(8'h02, ack);
            begin
                s3 = 0;
                while (scl_oen && s3 < 2000) begin
                    cyc(1);
                    s3++;
                end
                check_val("rst_pre_stretch", 32'(scl_oen), 32'd0);
                #3 reset_n_i = 1'b0;
                #1;
                check_val("rst_async_oen", 32'({scl_oen, sda_oen}), 32'b11);
                check_val("rst_async_ctl", 32'({busy_o, rx_valid_o, addressed_o}), 32'd0);
                cyc(2);
                reset_n_i = 1'b1;
            end
        join
        i2c_stop();
        cyc(20);
        check_val("post_rst_idle", 32'({busy_o, scl_oen, sda_oen}), 32'b011);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
